// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel round-robin stream mux with a registered output stage.
// Define STREAM_MUX_LOCK_EN to add in_last/out_last and hold the grant until a packet ends.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);
  logic [SEL_W-1:0] ptr, grant;
  logic any, load, lock;
  assign load = !out_valid || out_ready;
  // Scan downward so the channel nearest ptr+1 is the one left standing.
  always_comb begin
    grant = ptr;
    any = 1'b0;
    if (lock) begin
      any = in_valid[ptr];
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        if (in_valid[(int'(ptr) + k) % NUM_CH]) begin
          grant = SEL_W'((int'(ptr) + k) % NUM_CH);
          any = 1'b1;
        end
      end
    end
    in_ready = (rst_n && load && any) ? NUM_CH'(1) << grant : '0;
  end
`ifdef STREAM_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= 1'b0;
      out_last <= 1'b0;
    end else if (load && any) begin
      lock <= !in_last[grant];
      out_last <= in_last[grant];
    end
  end
`else
  assign lock = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= SEL_W'(NUM_CH - 1);
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[grant*DATA_W +: DATA_W];
        out_sel <= grant;
        ptr <= grant;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] in_data;
  logic [3:0] in_valid, in_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic out_valid, out_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [3:0] in_last;
  logic out_last;
`endif
  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last),
    .out_last(out_last),
`endif
    .out_data(out_data),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic [1:0] s);
    exp_q.push_back({d, s});
  endtask
  task automatic set_a;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
  endtask
  task automatic idle;
    repeat (2) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat: unexpected data=%h sel=%0d", out_data, out_sel);
      end else if ({out_data, out_sel} !== exp_q[0]) begin
        failures++;
        $display("FAIL beat: got data=%h sel=%0d expected data=%h sel=%0d",
                 out_data, out_sel, exp_q[0][9:2], exp_q[0][1:0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    in_valid = '1;
    out_ready = 1'b1;
    set_a();
`ifdef STREAM_MUX_LOCK_EN
    in_last = '1;
`endif
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_sel", 32'(out_sel), 0);
    chk("reset in_ready", 32'(in_ready), 0);
    // Round-robin from reset: six transfers starting at channel 0.
    push(8'hA0, 0); push(8'hA1, 1); push(8'hA2, 2);
    push(8'hA3, 3); push(8'hA0, 0); push(8'hA1, 1);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 in_valid = '0;
    idle();
    // Single channel 2, consecutive beats.
    push(8'h11, 2); push(8'h22, 2); push(8'h33, 2);
    in_valid = 4'b0100;
    in_data[23:16] = 8'h11;
    @(posedge clk); #1 in_data[23:16] = 8'h22;
    @(posedge clk); #1 in_data[23:16] = 8'h33;
    @(posedge clk); #1 in_valid = '0;
    idle();
    // Backpressure: ch3 loads, stalls three cycles, then ch0 loads on the draining edge.
    push(8'hA3, 3); push(8'hA0, 0);
    set_a();
    in_valid = '1;
    out_ready = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("stall out_data", 32'(out_data), 32'hA3);
      chk("stall out_sel", 32'(out_sel), 3);
      chk("stall in_ready", 32'(in_ready), 0);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    chk("no bubble out_valid", 32'(out_valid), 1);
    idle();
    // Asynchronous reset mid-stream with a held beat.
    in_valid = '1;
    out_ready = 1'b0;
    @(posedge clk);
    #3 chk("pre-reset out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1 chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset in_ready", 32'(in_ready), 0);
    push(8'hA0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = '0;
    idle();
`ifdef STREAM_MUX_LOCK_EN
    // ch1 packet B1,B2,(gap),B3 while ch0/ch2 wait; ch2 follows the unlock.
    push(8'hB1, 1); push(8'hB2, 1); push(8'hB3, 1); push(8'hA2, 2);
    in_last = 4'b1101;
    in_data[15:8] = 8'hB1;
    in_valid = 4'b0111;
    @(posedge clk); #1 in_data[15:8] = 8'hB2;
    @(posedge clk); #1 in_valid = 4'b0101;
    repeat (2) begin
      @(negedge clk);
      chk("lock gap out_valid", 32'(out_valid), 0);
      chk("lock gap in_ready", 32'(in_ready), 0);
      @(posedge clk);
    end
    #1 in_valid = 4'b0111;
    in_data[15:8] = 8'hB3;
    in_last = '1;
    @(posedge clk); #1 in_valid = 4'b0101;
    chk("lock out_last", 32'(out_last), 1);
    @(posedge clk); #1 in_valid = '0;
    idle();
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with round-robin arbitration and a registered output stage. It succeeds the combinational 4:1 mux for datapaths that need per-channel valid/ready flow control. Each source presents a DATA_W beat; the block picks one valid channel per cycle, registers the beat and reports which channel it came from. It sits between several producers and a single shared consumer (bus, FIFO, serialiser).

## Interface
- NUM_CH, 4: number of input channels; must be at least 2.
- DATA_W, 8: width of one data beat.
- SEL_W, $clog2(NUM_CH): derived localparam; width of the channel index.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*DATA_W  packed beats; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel beat valid.
- in_ready  output  NUM_CH  per-channel accept; combinational.
- in_last  input  NUM_CH  per-channel end-of-packet; present only with STREAM_MUX_LOCK_EN.
- out_data  output  DATA_W  registered beat.
- out_sel  output  SEL_W  registered source channel index of out_data.
- out_last  output  1  registered end-of-packet; present only with STREAM_MUX_LOCK_EN.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accept.

## Operation
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, rr pointer=NUM_CH-1, lock=0.
- Load enable: load = !out_valid || out_ready. The register holds one beat. It can be refilled in the same cycle it drains.
- Arbiter selects grant from the requests in_valid. The search starts at channel (ptr+1) mod NUM_CH, ascending, and wraps from NUM_CH-1 to 0. The first valid channel wins.
- in_ready[i] = load && (grant==i) && in_valid-any. At most one bit of in_ready is high in any cycle. in_ready never depends on out_valid of other blocks except through load.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. Effects on the next edge:
  - out_data takes channel i's slice.
  - out_sel becomes i.
  - out_valid becomes 1.
  - ptr becomes i.
- If load is high and no channel is valid, out_valid becomes 0 and out_data/out_sel hold their last values.
- If load is low (out_valid && !out_ready), all output registers hold. No in_ready is asserted.
- The arbiter is fair: a channel that stays valid waits at most NUM_CH-1 transfers.
- Reset is asynchronous. Asserting rst_n mid-stream discards the registered beat and returns every register to its reset value immediately. In-flight handshakes are lost.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- in_ready is a combinational function of in_valid, out_valid, out_ready and lock state. No combinational path exists from in_data to any output.
- The output is AXI-stream-like. While out_valid && !out_ready, out_data, out_sel and out_last are stable.

## Configuration
- STREAM_MUX_LOCK_EN defined: packet-lock mode. The in_last and out_last ports exist.
  - A transfer with in_last[i]=0 sets lock=1, and the grant stays on channel i.
  - While locked, only channel i can be granted. Other channels stall even if channel i is idle.
  - A transfer with in_last[i]=1 clears lock. Arbitration then resumes from ptr=i.
  - out_last is registered together with out_data.
- Not defined: in_last and out_last are absent, and arbitration is per beat. Packets from different channels may interleave.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_sel=0, in_ready=0. Release rst_n -> the first transfer comes from channel 0.
- Single channel: only ch2 is valid, sending 0x11,0x22,0x33, out_ready=1 -> out_data is 0x11,0x22,0x33 on consecutive cycles, out_sel=2 each time, 1-cycle latency.
- Round-robin: all four channels valid continuously with data 0xA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_sel are stable and in_ready=0. Raise out_ready -> the next beat loads on the same edge, with no bubble.
- Mid-operation reset: assert rst_n low asynchronously (between edges) while out_valid=1 -> out_valid drops to 0 immediately. After release, the first grant goes to channel 0.
- Lock mode (STREAM_MUX_LOCK_EN): ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are valid -> out_sel=1,1,1 then 2. Also drop ch1 valid mid-packet for 2 cycles -> out_valid=0 and no other channel is granted.
